// File: rtl/inference_ctrl_pkg.sv
// Shared types and widths for the inference controller.
// State encoding, datapath widths and small helpers used by the
// controller top, its optional watchdog and the bus interface.
package inference_ctrl_pkg;

  localparam int PIX_W = 16;
  localparam int CAT_W = 4;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_WAIT_STORE = 3'd2,
    S_RUN        = 3'd3,
    S_HOLD       = 3'd4,
    S_ERR        = 3'd5
  } state_t;

  // States in which the datapath may stall and the watchdog is armed.
  function automatic logic is_watched(input state_t s);
    return (s == S_WAIT_STORE) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/inference_ctrl_if.sv
// Bus between the inference controller and its surroundings: the
// host/pixel source, the datapath handshake and the result channel.
// master = environment side, slave = controller side.
interface inference_ctrl_if;
  import inference_ctrl_pkg::*;

  logic                    req;
  logic                    pix_valid;
  logic signed [PIX_W-1:0] pix_in;
  logic                    pix_ready;
  logic                    store;
  logic signed [PIX_W-1:0] image_pixel;
  logic                    store_finish;
  logic                    start;
  logic                    one_end;
  logic signed [CAT_W-1:0] categories;
  logic                    result_valid;
  logic signed [CAT_W-1:0] result;
  logic                    result_ready;
  logic                    busy;
  logic                    timeout_err;
  logic                    clear_err;

  modport master (
    output req, pix_valid, pix_in, store_finish, one_end, categories,
           result_ready, clear_err,
    input  pix_ready, store, image_pixel, start, result_valid, result,
           busy, timeout_err
  );

  modport slave (
    input  req, pix_valid, pix_in, store_finish, one_end, categories,
           result_ready, clear_err,
    output pix_ready, store, image_pixel, start, result_valid, result,
           busy, timeout_err
  );

endinterface

// File: rtl/inference_ctrl_watchdog.sv
// ctrl_watchdog: stall detector for the inference controller.
// Counts cycles spent while enabled; clear restarts the count. expired
// asserts on the cycle whose closing edge completes TIMEOUT cycles.
// Only instantiated when INFERENCE_CTRL_WATCHDOG_EN is defined.
module ctrl_watchdog
  import inference_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise count up and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of elapsed cycles minus one, so the limit
  // compare fires on the TIMEOUT-th cycle in the watched state.
  assign expired_o = enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/inference_ctrl.sv
// inference_ctrl: sequences one inference -- pixel load, wait for the
// datapath to commit the image, run, and hold the class result until the
// consumer takes it. All outputs are registered.
// Optional watchdog: define INFERENCE_CTRL_WATCHDOG_EN to add a stall timer
// on WAIT_STORE/RUN that traps into ERR with a sticky timeout_err.
module inference_ctrl
  import inference_ctrl_pkg::*;
#(
  parameter int N_PIXELS = 784,
  parameter int TIMEOUT  = 65535
) (
  input logic             clk,
  input logic             n_reset,
  inference_ctrl_if.slave ctrl_if
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(N_PIXELS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        pix_cnt_q;
  logic [CNT_W-1:0]        pix_cnt_d;
  logic                    pix_ready_q;
  logic                    store_q;
  logic signed [PIX_W-1:0] image_pixel_q;
  logic                    start_q;
  logic                    result_valid_q;
  logic signed [CAT_W-1:0] result_q;
  logic                    busy_q;
  logic                    accept;
  logic                    expired;

  assign accept = (state_q == S_LOAD) && pix_ready_q && ctrl_if.pix_valid;

`ifdef INFERENCE_CTRL_WATCHDOG_EN
  logic timeout_err_q;

  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .n_reset   (n_reset),
    .clear_i   (state_d != state_q),
    .enable_i  (is_watched(state_q)),
    .expired_o (expired)
  );

  assign ctrl_if.timeout_err = timeout_err_q;
`else
  assign expired             = 1'b0;
  assign ctrl_if.timeout_err = 1'b0;
`endif

  // Next-state and pixel-count logic; advancing events beat a timeout.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_if.req) begin
          state_d   = S_LOAD;
          pix_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d = S_WAIT_STORE;
          end
        end
      end
      S_WAIT_STORE: begin
        if (ctrl_if.store_finish) begin
          state_d = S_RUN;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_RUN: begin
        if (ctrl_if.one_end) begin
          state_d = S_HOLD;
        end else if (expired) begin
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        if (ctrl_if.result_ready) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
`ifdef INFERENCE_CTRL_WATCHDOG_EN
        if (ctrl_if.clear_err) begin
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state plus registered outputs derived from the upcoming state.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q        <= S_IDLE;
      pix_cnt_q      <= '0;
      pix_ready_q    <= 1'b0;
      store_q        <= 1'b0;
      image_pixel_q  <= '0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      busy_q         <= 1'b0;
`ifdef INFERENCE_CTRL_WATCHDOG_EN
      timeout_err_q  <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      pix_cnt_q      <= pix_cnt_d;
      pix_ready_q    <= (state_d == S_LOAD);
      store_q        <= accept;
      if (accept) begin
        image_pixel_q <= ctrl_if.pix_in;
      end
      start_q        <= (state_d == S_RUN);
      if ((state_q == S_RUN) && (state_d == S_HOLD)) begin
        result_q <= ctrl_if.categories;
      end
      result_valid_q <= (state_d == S_HOLD);
      busy_q         <= (state_d != S_IDLE);
`ifdef INFERENCE_CTRL_WATCHDOG_EN
      timeout_err_q  <= (state_d == S_ERR);
`endif
    end
  end

  assign ctrl_if.pix_ready    = pix_ready_q;
  assign ctrl_if.store        = store_q;
  assign ctrl_if.image_pixel  = image_pixel_q;
  assign ctrl_if.start        = start_q;
  assign ctrl_if.result_valid = result_valid_q;
  assign ctrl_if.result       = result_q;
  assign ctrl_if.busy         = busy_q;

endmodule

// File: doc/inference_ctrl.md
INFERENCE_CTRL -- requirements
Module: inference_ctrl

Interface
REQ-001 Parameter: N_PIXELS, default 784, number of image pixels loaded per inference (range 1..65535).
REQ-002 Parameter: TIMEOUT, default 65535, maximum cycles allowed in WAIT_STORE or RUN before an error (range 1..65535).
REQ-003 Port: clk  in  1  single clock; all logic on rising edge.
REQ-004 Port: n_reset  in  1  reset, synchronous, active-low.
REQ-005 Port: req  in  1  request to start one inference; sampled in IDLE only.
REQ-006 Port: pix_valid / pix_in  in  1 / 16 signed  incoming pixel stream.
REQ-007 Port: pix_ready  out  1  pixel accepted when pix_valid and pix_ready are both 1 on the same edge.
REQ-008 Port: store / image_pixel  out  1 / 16 signed  registered pixel write into the datapath image buffer.
REQ-009 Port: store_finish  in  1  datapath has committed the full image.
REQ-010 Port: start  out  1  datapath run enable, level.
REQ-011 Port: one_end / categories  in  1 / 4 signed  datapath classification done / class index.
REQ-012 Port: result_valid / result / result_ready  out / out / in  1 / 4 signed / 1  result handshake.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: timeout_err / clear_err  out / in  1 / 1  sticky watchdog error and its clear.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, WAIT_STORE, RUN, HOLD, ERR, one-hot or binary encoded.
REQ-016 IDLE->LOAD on req=1; all other inputs in IDLE SHALL be ignored.
REQ-017 In LOAD, pix_ready SHALL be 1; each accepted pixel SHALL produce store=1 and image_pixel=pix_in exactly one cycle later, with store=0 otherwise.
REQ-018 A 16-bit pixel counter SHALL increment per accepted pixel; acceptance of pixel N_PIXELS SHALL move LOAD->WAIT_STORE and drop pix_ready on the next cycle, so no extra pixel is ever accepted.
REQ-019 WAIT_STORE->RUN on store_finish=1; store_finish arriving before WAIT_STORE SHALL be ignored.
REQ-020 In RUN, start SHALL be 1; start SHALL be 0 in every other state.
REQ-021 RUN->HOLD on one_end=1; result SHALL capture categories on that edge, and result_valid SHALL be 1 from the next cycle.
REQ-022 In HOLD, result_valid SHALL stay 1 and result SHALL stay stable until result_ready=1; then HOLD->IDLE and result_valid=0 on the next cycle, with result retaining its value.
REQ-023 A new req SHALL be ignored while busy=1; there SHALL be no queueing.
REQ-024 Latency from the accept of the last pixel to start=1 SHALL be 1 cycle plus the store_finish wait.

Reset
REQ-025 With n_reset=0 on a rising edge: state=IDLE, counters=0, and pix_ready, store, start, result_valid, busy, timeout_err=0; image_pixel=0 and result=0.
REQ-026 Reset mid-operation SHALL abort immediately with no partial result; the datapath sees start=0 next cycle.

Configuration
REQ-027 Macro INFERENCE_CTRL_WATCHDOG_EN: when defined, a cycle counter SHALL clear on entry to WAIT_STORE or RUN and count while in them.
REQ-028 With INFERENCE_CTRL_WATCHDOG_EN defined, reaching TIMEOUT SHALL go ERR and set timeout_err=1.
REQ-029 In ERR, busy SHALL be 1 and timeout_err SHALL stay 1; clear_err=1 SHALL go IDLE and clear timeout_err next cycle.
REQ-030 When the macro is undefined, the counter and ERR logic SHALL be absent, timeout_err SHALL be tied 0, and clear_err SHALL be ignored.
REQ-031 If a timeout and an advancing event (store_finish or one_end) fall on the same cycle, the advancing event SHALL win.

Structure
REQ-032 Package inference_ctrl_pkg SHALL hold the state enum typedef, PIX_W=16 and CAT_W=4.
REQ-033 The watchdog SHALL be sub-module ctrl_watchdog (clear, enable, TIMEOUT -> expired), instantiated only under the macro.

Verification
REQ-034 N_PIXELS=4, req pulse, 4 pixels 0x0001..0x0004 back-to-back -> store pulses carry 1,2,3,4 each one cycle after accept; pix_ready=0 after the 4th accept.
REQ-035 store_finish 3 cycles after the last pixel -> start=1 the following cycle; one_end with categories=7 -> result_valid=1, result=7, start=0.
REQ-036 result_ready held 0 for 10 cycles, then 1 -> result stable for 10 cycles, then IDLE, busy=0.
REQ-037 Macro defined, TIMEOUT=8, no store_finish -> timeout_err=1 after 8 cycles in WAIT_STORE; clear_err -> IDLE.
REQ-038 n_reset=0 asserted during RUN -> all outputs 0 next edge; a subsequent req starts a clean load.
REQ-039 req pulsed during HOLD, and a 5th pixel offered during WAIT_STORE -> both ignored; pixel count stays 4.
